// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard sequencer.
// Holds the register index width and the sequencer state type.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_FILE_ADDR_LEN = 5;

    typedef enum logic [1:0] {
        RUN,
        MC_WAIT,
        MEM_WAIT
    } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_raw_hazard_detect.sv
// RAW hazard detection between the ID instruction and EXE/MEM producers.
// Register 0 never produces a hazard.
module raw_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_FILE_ADDR_LEN-1:0] id_src1,
    input  logic [REG_FILE_ADDR_LEN-1:0] id_src2,
    input  logic                         id_uses_src2,
    input  logic [REG_FILE_ADDR_LEN-1:0] exe_dest,
    input  logic                         exe_wb_en,
    input  logic                         exe_mem_r_en,
    input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
    input  logic                         mem_wb_en,
    input  logic                         fwd_en,
    output logic                         use_stall
);

    function automatic logic raw_hit(
        input logic [REG_FILE_ADDR_LEN-1:0] d,
        input logic                         we
    );
        return we && (d != '0) &&
               ((id_src1 == d) || (id_uses_src2 && (id_src2 == d)));
    endfunction

    logic load_hit;
    logic nofwd_hit;

    always_comb begin
        load_hit  = raw_hit(exe_dest, exe_wb_en && exe_mem_r_en);
        // Without forwarding every in-flight writer must retire first.
        nofwd_hit = !fwd_en &&
                    (raw_hit(exe_dest, exe_wb_en) ||
                     raw_hit(mem_dest, mem_wb_en));
        use_stall = load_hit || nofwd_hit;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers.
// Also keeps saturating stall-cycle and branch-flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [REG_FILE_ADDR_LEN-1:0] id_src1,
    input  logic [REG_FILE_ADDR_LEN-1:0] id_src2,
    input  logic                         id_uses_src2,
    input  logic [REG_FILE_ADDR_LEN-1:0] exe_dest,
    input  logic                         exe_wb_en,
    input  logic                         exe_mem_r_en,
    input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
    input  logic                         mem_wb_en,
    input  logic                         fwd_en,
    input  logic                         exe_br_taken,
    input  logic                         exe_mc_op,
    input  logic                         mem_access,
    input  logic                         dmem_ready,
    output logic                         pc_en,
    output logic                         ifid_en,
    output logic                         idex_en,
    output logic                         exmem_en,
    output logic                         ifid_flush,
    output logic                         idex_flush,
    output logic                         exmem_flush,
    output logic [CNT_W-1:0]             stall_cycles,
    output logic [CNT_W-1:0]             flush_events
);

    localparam int MCW = $clog2(MC_LATENCY);

    generate
        if (MC_LATENCY < 2) begin : g_bad_latency
            $error("MC_LATENCY must be at least 2");
        end
    endgenerate

    hz_state_t      state, state_nxt;
    logic [MCW-1:0] mc_cnt, mc_cnt_nxt;
    logic           use_stall;
    logic           br_flush;
    logic           run_rules;

    raw_hazard_detect u_raw (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src2 (id_uses_src2),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .fwd_en       (fwd_en),
        .use_stall    (use_stall)
    );

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_nxt   = state;
        mc_cnt_nxt  = mc_cnt;
        br_flush    = 1'b0;
        run_rules   = 1'b0;

        unique case (state)
            RUN:      run_rules = 1'b1;
            MEM_WAIT: run_rules = dmem_ready;
            MC_WAIT: begin
                if (mc_cnt != '0) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    mc_cnt_nxt  = mc_cnt - MCW'(1);
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        if (state == MEM_WAIT && !dmem_ready) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end

        if (run_rules) begin
            state_nxt = RUN;
            if (mem_access && !dmem_ready) begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                idex_en   = 1'b0;
                exmem_en  = 1'b0;
                state_nxt = MEM_WAIT;
            end else if (exe_br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                br_flush   = 1'b1;
            end else if (exe_mc_op) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_flush = 1'b1;
                mc_cnt_nxt  = MCW'(MC_LATENCY - 2);
                state_nxt   = MC_WAIT;
            end else if (use_stall) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        // Reset drops any stall at once rather than waiting for an edge.
        if (!rstn) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            br_flush    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= RUN;
            mc_cnt       <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
            if (!pc_en && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (br_flush && flush_events != '1)
                flush_events <= flush_events + CNT_W'(1);
        end
    end

    a_br_mc_excl: assert property (@(posedge clk) disable iff (!rstn)
        !(exe_br_taken && exe_mc_op));

    a_no_mem_in_mc: assert property (@(posedge clk) disable iff (!rstn)
        !(state == MC_WAIT && mem_access));

    a_en_flush: assert property (@(posedge clk) disable iff (!rstn)
        !((!ifid_en && ifid_flush) ||
          (!idex_en && idex_flush) ||
          (!exmem_en && exmem_flush)));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl.
// Expected controls come from a cycle-level model of the pipeline rules.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int MC_LATENCY = 4;
    localparam int CNT_W      = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
    logic id_uses_src2, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en;
    logic exe_br_taken, exe_mc_op, mem_access, dmem_ready;
    logic pc_en, ifid_en, idex_en, exmem_en;
    logic ifid_flush, idex_flush, exmem_flush;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int n_cmp = 0;
    int n_err = 0;

    // Model: remaining cycles of a multi-cycle op, and a pending memory wait.
    int m_rem = 0;
    bit m_memw = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MC_LATENCY(MC_LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
        .exe_br_taken(exe_br_taken), .exe_mc_op(exe_mc_op),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    wire [6:0] outs = {pc_en, ifid_en, idex_en, exmem_en,
                       ifid_flush, idex_flush, exmem_flush};

    localparam logic [6:0] O_DEF    = 7'b1111_000;
    localparam logic [6:0] O_FREEZE = 7'b0000_000;
    localparam logic [6:0] O_MC     = 7'b0001_001;
    localparam logic [6:0] O_BR     = 7'b1111_110;
    localparam logic [6:0] O_BUB    = 7'b0011_010;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard();
        logic [4:0] dst [2];
        bit act [2];
        dst[0] = exe_dest;
        act[0] = exe_wb_en && (exe_mem_r_en || !fwd_en);
        dst[1] = mem_dest;
        act[1] = mem_wb_en && !fwd_en;
        for (int i = 0; i < 2; i++)
            if (act[i] && dst[i] != 0 &&
                (id_src1 == dst[i] || (id_uses_src2 && id_src2 == dst[i])))
                return 1;
        return 0;
    endfunction

    task automatic model_eval(output logic [6:0] o, output int n_rem,
                              output bit n_memw, output bit brf);
        o = O_DEF;
        n_rem = m_rem;
        n_memw = m_memw;
        brf = 0;
        if (m_rem > 0) begin
            if (m_rem > 1) o = O_MC;
            n_rem = m_rem - 1;
        end else if (m_memw && !dmem_ready) begin
            o = O_FREEZE;
        end else if (mem_access && !dmem_ready) begin
            o = O_FREEZE;
            n_memw = 1;
        end else begin
            n_memw = 0;
            if (exe_br_taken) begin
                o = O_BR;
                brf = 1;
            end else if (exe_mc_op) begin
                o = O_MC;
                n_rem = MC_LATENCY - 1;
            end else if (model_hazard()) begin
                o = O_BUB;
            end
        end
    endtask

    task automatic cyc(input string tag);
        logic [6:0] o;
        int nr;
        bit nm, bf;
        #1;
        model_eval(o, nr, nm, bf);
        chk({tag, "_ctl"}, 32'(outs), 32'(o));
        @(posedge clk);
        m_rem = nr;
        m_memw = nm;
        if (!o[6]) m_stall++;
        if (bf) m_flush++;
        #1;
        chk({tag, "_stall"}, stall_cycles, m_stall);
        chk({tag, "_flush"}, flush_events, m_flush);
    endtask

    task automatic idle();
        id_src1 = 0; id_src2 = 0; id_uses_src2 = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_dest = 0; mem_wb_en = 0; fwd_en = 1;
        exe_br_taken = 0; exe_mc_op = 0;
        mem_access = 0; dmem_ready = 1;
    endtask

    initial begin
        idle();
        #2;
        chk("rst_ctl", 32'(outs), 32'(O_DEF));
        chk("rst_stall", stall_cycles, 0);
        chk("rst_flush", flush_events, 0);
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;

        // load-use
        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5; id_src1 = 5;
        cyc("loaduse");
        chk("loaduse_cnt", stall_cycles, 1);
        exe_dest = 0;
        cyc("loaduse_r0");
        chk("loaduse_r0_cnt", stall_cycles, 1);

        // branch beats load-use
        exe_dest = 5; exe_br_taken = 1;
        cyc("branch");
        chk("branch_cnt", flush_events, 1);
        chk("branch_stall", stall_cycles, 1);

        // multi-cycle op
        idle();
        exe_mc_op = 1;
        for (int i = 0; i < MC_LATENCY; i++) cyc("mc");
        chk("mc_cnt", stall_cycles, 1 + 3);
        exe_mc_op = 0;
        cyc("mc_after");

        // memory wait with pending multi-cycle op
        mem_access = 1; dmem_ready = 0; exe_mc_op = 1;
        cyc("memw0");
        cyc("memw1");
        dmem_ready = 1;
        cyc("memw_rel");
        mem_access = 0;
        cyc("memw_mc1");
        cyc("memw_mc2");
        cyc("memw_mcrel");
        chk("memw_cnt", stall_cycles, 4 + 5);
        exe_mc_op = 0;

        // no-forward mode
        idle();
        fwd_en = 0; mem_wb_en = 1; mem_dest = 7;
        id_uses_src2 = 1; id_src2 = 7;
        cyc("nofwd");
        chk("nofwd_cnt", stall_cycles, 10);
        fwd_en = 1;
        cyc("fwd");
        chk("fwd_cnt", stall_cycles, 10);

        // async reset in the middle of a multi-cycle wait
        idle();
        exe_mc_op = 1;
        cyc("mcr0");
        cyc("mcr1");
        rstn = 0;
        #1;
        chk("arst_ctl", 32'(outs), 32'(O_DEF));
        chk("arst_stall", stall_cycles, 0);
        chk("arst_flush", flush_events, 0);
        m_rem = 0; m_memw = 0; m_stall = 0; m_flush = 0;
        exe_mc_op = 0;
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        cyc("post_rst");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            id_src1 = 5'($urandom_range(0, 7));
            id_src2 = 5'($urandom_range(0, 7));
            id_uses_src2 = 1'($urandom);
            exe_dest = 5'($urandom_range(0, 7));
            exe_wb_en = 1'($urandom);
            exe_mem_r_en = 1'($urandom);
            mem_dest = 5'($urandom_range(0, 7));
            mem_wb_en = 1'($urandom);
            fwd_en = ($urandom_range(0, 3) != 0);
            exe_mc_op = ($urandom_range(0, 7) == 0);
            exe_br_taken = !exe_mc_op && ($urandom_range(0, 5) == 0);
            mem_access = (m_rem == 0) && ($urandom_range(0, 3) == 0);
            dmem_ready = ($urandom_range(0, 2) != 0);
            cyc("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
